// File: rtl/stream_register_pkg.sv
// Shared constants for the single-entry valid/ready stream register.
package stream_register_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32'd8;

endpackage

// File: rtl/stream_register.sv
// One-entry valid/ready pipeline register: valid and data are registered,
// ready passes through combinationally so a full register still streams.
module stream_register
    import stream_register_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  testmode_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  valid_d, valid_q;
    logic [DATA_WIDTH-1:0] data_d,  data_q;
    logic                  ld_s;
    logic                  unused_testmode_s;

    assign unused_testmode_s = testmode_i;

    // Free slot when empty or when the held item is consumed this cycle.
    assign ready_o = ready_i | ~valid_q;
    assign ld_s    = valid_i & ready_o;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Next-state selection; a clear drops both the held and the offered item.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
            data_d  = {DATA_WIDTH{1'b0}};
        end else begin
            if (ready_o) begin
                valid_d = valid_i;
            end else begin
                valid_d = valid_q;
            end
            if (ld_s) begin
                data_d = data_i;
            end else begin
                data_d = data_q;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_stream_register.sv
// Scenario bench for stream_register with a handshake scoreboard monitor.
module tb_stream_register;

    localparam int DW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clr_i;
    logic          testmode_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_i;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] data_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [DW-1:0] exp_q [$];

    stream_register #(.DATA_WIDTH(DW)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (clr_i),
        .testmode_i (testmode_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard: push accepted inputs, pop and compare delivered outputs.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            total_cnt++;
            if (valid_o !== (exp_q.size() != 0)) begin
                $display("FAIL sb_valid: valid_o=%b expected=%b", valid_o, exp_q.size() != 0);
            end else begin
                pass_cnt++;
            end
            total_cnt++;
            if (ready_o !== (ready_i | (exp_q.size() == 0))) begin
                $display("FAIL sb_ready: ready_o=%b expected=%b", ready_o, ready_i | (exp_q.size() == 0));
            end else begin
                pass_cnt++;
            end
            if (clr_i) begin
                exp_q.delete();
            end else begin
                if (valid_o && ready_i && exp_q.size() != 0) begin
                    total_cnt++;
                    if (data_o !== exp_q[0]) begin
                        $display("FAIL sb_data: data_o=%h expected=%h", data_o, exp_q[0]);
                    end else begin
                        pass_cnt++;
                    end
                    void'(exp_q.pop_front());
                end
                if (valid_i && ready_o) begin
                    exp_q.push_back(data_i);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; clr_i = 1'b0; testmode_i = 1'b0;
        valid_i = 1'b0; ready_i = 1'b0; data_i = 8'h00;
        #3;
        total_cnt++;
        if (valid_o !== 1'b0 || data_o !== 8'h00 || ready_o !== 1'b1) begin
            $display("FAIL reset: valid_o=%b data_o=%h ready_o=%b expected 0/00/1", valid_o, data_o, ready_o);
        end else begin
            pass_cnt++;
        end
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single_and_hold();
        valid_i = 1'b1; data_i = 8'h5A; ready_i = 1'b0;
        #1;
        total_cnt++;
        if (ready_o !== 1'b1) begin
            $display("FAIL single_ready_empty: ready_o=%b expected=1", ready_o);
        end else begin
            pass_cnt++;
        end
        tick();
        total_cnt++;
        if (valid_o !== 1'b1 || data_o !== 8'h5A || ready_o !== 1'b0) begin
            $display("FAIL single_load: valid_o=%b data_o=%h ready_o=%b expected 1/5a/0", valid_o, data_o, ready_o);
        end else begin
            pass_cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            data_i = 8'(i * 37 + 3);
            tick();
            total_cnt++;
            if (valid_o !== 1'b1 || data_o !== 8'h5A) begin
                $display("FAIL hold_%0d: valid_o=%b data_o=%h expected 1/5a", i, valid_o, data_o);
            end else begin
                pass_cnt++;
            end
        end
        valid_i = 1'b0; ready_i = 1'b1;
        #1;
        total_cnt++;
        if (ready_o !== 1'b1) begin
            $display("FAIL pop_ready_comb: ready_o=%b expected=1", ready_o);
        end else begin
            pass_cnt++;
        end
        tick();
        total_cnt++;
        if (valid_o !== 1'b0) begin
            $display("FAIL pop_empty: valid_o=%b expected=0", valid_o);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_streaming(input logic tm);
        testmode_i = tm;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            data_i  = 8'(i + 1);
            tick();
            total_cnt++;
            if (valid_o !== 1'b1 || data_o !== 8'(i + 1) || ready_o !== 1'b1) begin
                $display("FAIL stream_tm%0d_%0d: valid_o=%b data_o=%h ready_o=%b expected 1/%h/1",
                         tm, i, valid_o, data_o, ready_o, 8'(i + 1));
            end else begin
                pass_cnt++;
            end
        end
        valid_i = 1'b0;
        tick();
        total_cnt++;
        if (valid_o !== 1'b0) begin
            $display("FAIL stream_tm%0d_drain: valid_o=%b expected=0", tm, valid_o);
        end else begin
            pass_cnt++;
        end
        testmode_i = 1'b0;
    endtask

    task automatic test_clear();
        valid_i = 1'b1; data_i = 8'h7F; ready_i = 1'b0;
        tick();
        total_cnt++;
        if (valid_o !== 1'b1 || data_o !== 8'h7F) begin
            $display("FAIL clear_load: valid_o=%b data_o=%h expected 1/7f", valid_o, data_o);
        end else begin
            pass_cnt++;
        end
        data_i = 8'h11; ready_i = 1'b1; clr_i = 1'b1;
        #1;
        total_cnt++;
        if (ready_o !== 1'b1) begin
            $display("FAIL clear_ready: ready_o=%b expected=1", ready_o);
        end else begin
            pass_cnt++;
        end
        tick();
        clr_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        #1;
        total_cnt++;
        if (valid_o !== 1'b0 || data_o !== 8'h00) begin
            $display("FAIL clear_result: valid_o=%b data_o=%h expected 0/00", valid_o, data_o);
        end else begin
            pass_cnt++;
        end
        tick();
    endtask

    task automatic test_async_reset();
        valid_i = 1'b1; data_i = 8'hAB; ready_i = 1'b0;
        tick();
        valid_i = 1'b0;
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        total_cnt++;
        if (valid_o !== 1'b0 || data_o !== 8'h00 || ready_o !== 1'b1) begin
            $display("FAIL async_reset: valid_o=%b data_o=%h ready_o=%b expected 0/00/1", valid_o, data_o, ready_o);
        end else begin
            pass_cnt++;
        end
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_and_hold();
        test_streaming(1'b0);
        test_streaming(1'b1);
        test_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/stream_register.md
# stream_register

Single-stage valid/ready pipeline register for a narrow data stream. Cuts the valid and data paths between producer and consumer, at full throughput; the ready path stays combinational. Used as a one-entry command buffer, e.g. holding an 8-bit burst length between a write-side pusher and a read-side popper inside an AXI filter.

## Interface
- DATA_WIDTH, default 8: width of data_i/data_o.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- clr_i  input  1  synchronous clear; empties the register.
- testmode_i  input  1  test-mode strap; no functional effect, accepted for port compatibility.
- valid_i  input  1  upstream data valid.
- ready_o  output  1  upstream ready; a handshake is valid_i & ready_o.
- data_i  input  DATA_WIDTH  upstream payload.
- valid_o  output  1  downstream data valid (registered).
- ready_i  input  1  downstream ready.
- data_o  output  DATA_WIDTH  downstream payload (registered).

## Operation
- State: valid_q (1 bit), data_q (DATA_WIDTH bits).
- valid_o = valid_q; data_o = data_q.
- ready_o = ready_i | ~valid_q (combinational). Accepts input when empty or when the held item leaves this cycle.
- Load enable: ld = valid_i & ready_o.
- Next state, clr_i has highest priority:
  - clr_i=1: valid_q<=0, data_q<=0, regardless of valid_i/ready_i.
  - else if ready_o: valid_q<=valid_i.
  - else: valid_q holds.
  - else if ld: data_q<=data_i; otherwise data_q holds.
- Full (valid_q=1, ready_i=0): ready_o=0, data_q and valid_q stable. Upstream must hold valid_i/data_i (AXI-style: valid must not drop without a handshake).
- Simultaneous pop and push (valid_q=1, ready_i=1, valid_i=1): old item leaves, new item loads the same edge, no bubble.
- Pop without push: valid_q falls to 0 next cycle.
- Data of a discarded/cleared item is lost; clr_i during a pending handshake drops both the held and the offered item. ready_o still reflects the formula during clr_i.
- testmode_i is ignored.

## Timing
- Reset (rst_ni=0, asynchronous): valid_q=0, data_q=0. Hence valid_o=0, data_o=0, ready_o=1 during and after reset.
- Latency: data accepted at edge N appears on data_o with valid_o=1 immediately after edge N, so 1 cycle.
- Throughput: 1 item/cycle when ready_i is held high.
- Combinational path exists only from ready_i to ready_o. No path from valid_i/data_i to any output.
- Reset mid-operation discards the held item immediately, without waiting for the clock.

## Structure
- A single flat module with no sub-modules; the two registers use the async-reset flop idiom.
- No package types needed. When instantiated for AXI, DATA_WIDTH=8 carries axi len, and the payload typedef comes from the user's AXI package.

## Test plan
- Reset: assert rst_ni=0 mid-cycle with valid_q=1 -> valid_o=0, data_o=0x00, ready_o=1 immediately.
- Single transfer: valid_i=1, data_i=0x5A, ready_i=0 for one cycle -> next cycle valid_o=1, data_o=0x5A, ready_o=0. Then ready_i=1 -> ready_o=1 the same cycle. With valid_i=0, valid_o=0 next cycle.
- Backpressure hold: while full with ready_i=0, toggle data_i (protocol violation aside) -> data_o stays 0x5A, valid_o stays 1 for 5 cycles.
- Streaming: ready_i=1, valid_i=1, data_i=0x01,0x02,0x03 on consecutive cycles -> data_o=0x01,0x02,0x03 one cycle later each, valid_o continuous, ready_o constantly 1.
- Clear: full with 0x7F, valid_i=1, data_i=0x11, clr_i=1 for one cycle -> next cycle valid_o=0, data_o=0x00; 0x11 is not captured.
- testmode_i=1 during the streaming test -> identical results.
